// File: rtl/subservient_sram_bridge.sv
// Byte-wide subservient SRAM port to a wide 1RW+1R macro (OpenRAM style).
// Byte writes to the same word are coalesced in a one-word buffer and issued
// as a single masked macro write; reads forward unflushed bytes.
module subservient_sram_bridge #(
  parameter int AW           = 13,
  parameter int DW           = 32,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [AW-1:0]                 i_waddr,
  input  logic [7:0]                    i_wdata,
  input  logic                          i_wen,
  input  logic [AW-1:0]                 i_raddr,
  input  logic                          i_ren,
  output logic [7:0]                    o_rdata,
  input  logic                          i_flush,
  output logic                          o_idle,
  output logic                          o_mem_csb0,
  output logic                          o_mem_web0,
  output logic [DW/8-1:0]               o_mem_wmask0,
  output logic [AW-$clog2(DW/8)-1:0]    o_mem_addr0,
  output logic [DW-1:0]                 o_mem_din0,
  output logic                          o_mem_csb1,
  output logic [AW-$clog2(DW/8)-1:0]    o_mem_addr1,
  input  logic [DW-1:0]                 i_mem_dout1
);

  localparam int BW      = DW / 8;
  localparam int LBW     = $clog2(BW);
  localparam int WAW     = AW - LBW;
  localparam int CNT_MAX = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES : 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Buffer state: the valid flag doubles as the EMPTY/PENDING state.
  localparam logic ST_EMPTY   = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  logic           r_buf_valid;
  logic [WAW-1:0] r_buf_addr;
  logic [BW-1:0]  r_buf_mask;
  logic [DW-1:0]  r_buf_data;
  logic [CW-1:0]  r_idle_cnt;

  logic           r_rd_act;
  logic           r_rd_hit;
  logic [7:0]     r_rd_byte;
  logic [LBW-1:0] r_rd_lane;
  logic [7:0]     r_rdata;

  logic [WAW-1:0] w_wr_word, w_rd_word;
  logic [LBW-1:0] w_wr_lane, w_rd_lane;
  logic           w_pending, w_timeout, w_flush, w_merge;
  logic           w_buf_valid_nxt;
  logic [WAW-1:0] w_buf_addr_nxt;
  logic [BW-1:0]  w_buf_mask_nxt;
  logic [DW-1:0]  w_buf_data_nxt;
  logic [CW-1:0]  w_idle_cnt_nxt;
  logic           w_fwd_hit;
  logic [7:0]     w_fwd_byte;
  logic [7:0]     w_mem_byte;
  logic [7:0]     w_rdata;

  assign w_wr_word = i_waddr[AW-1:LBW];
  assign w_wr_lane = i_waddr[LBW-1:0];
  assign w_rd_word = i_raddr[AW-1:LBW];
  assign w_rd_lane = i_raddr[LBW-1:0];

  assign w_pending = (r_buf_valid == ST_PENDING);
  assign w_timeout = (FLUSH_CYCLES != 0) && (r_idle_cnt == CW'(CNT_MAX));
  // Reset must never let a discarded word reach the macro.
  assign w_flush   = ~i_rst & w_pending &
                     ((i_wen & (w_wr_word != r_buf_addr)) | (&r_buf_mask) | i_flush | w_timeout);
  assign w_merge   = i_wen & w_pending & ~w_flush;

  // Next buffer contents: merge into the held word or start a fresh one.
  always_comb begin
    w_buf_valid_nxt = r_buf_valid;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_mask_nxt  = r_buf_mask;
    w_buf_data_nxt  = r_buf_data;
    if (i_wen) begin
      if (!w_merge) begin
        w_buf_mask_nxt = '0;
        w_buf_addr_nxt = w_wr_word;
      end
      w_buf_valid_nxt = ST_PENDING;
      for (int l = 0; l < BW; l++) begin
        if (w_wr_lane == LBW'(l)) begin
          w_buf_mask_nxt[l]         = 1'b1;
          w_buf_data_nxt[8*l +: 8]  = i_wdata;
        end
      end
    end else if (w_flush) begin
      w_buf_valid_nxt = ST_EMPTY;
      w_buf_mask_nxt  = '0;
    end
  end

  // Idle counter: cleared by activity, counts quiet PENDING cycles, saturates.
  always_comb begin
    w_idle_cnt_nxt = r_idle_cnt;
    if (i_wen || w_flush) begin
      w_idle_cnt_nxt = '0;
    end else if (w_pending && (r_idle_cnt != CW'(CNT_MAX))) begin
      w_idle_cnt_nxt = r_idle_cnt + CW'(1);
    end
  end

  // Forward view: buffered bytes of the read word, overridden by a same-cycle write.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_byte = 8'h00;
    if (w_pending && (r_buf_addr == w_rd_word)) begin
      for (int l = 0; l < BW; l++) begin
        if ((w_rd_lane == LBW'(l)) && r_buf_mask[l]) begin
          w_fwd_hit  = 1'b1;
          w_fwd_byte = r_buf_data[8*l +: 8];
        end
      end
    end
    if (i_wen && (w_wr_word == w_rd_word) && (w_wr_lane == w_rd_lane)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_byte = i_wdata;
    end
  end

  // Select the addressed lane of the macro read word.
  always_comb begin
    w_mem_byte = 8'h00;
    for (int l = 0; l < BW; l++) begin
      if (r_rd_lane == LBW'(l)) w_mem_byte = i_mem_dout1[8*l +: 8];
    end
  end

  assign w_rdata = r_rd_act ? (r_rd_hit ? r_rd_byte : w_mem_byte) : r_rdata;

  // Buffer, idle counter and read-return state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf_valid <= ST_EMPTY;
      r_buf_addr  <= '0;
      r_buf_mask  <= '0;
      r_buf_data  <= '0;
      r_idle_cnt  <= '0;
      r_rd_act    <= 1'b0;
      r_rd_hit    <= 1'b0;
      r_rd_byte   <= 8'h00;
      r_rd_lane   <= '0;
      r_rdata     <= 8'h00;
    end else begin
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_mask  <= w_buf_mask_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_rd_act    <= i_ren;
      r_rd_hit    <= w_fwd_hit;
      r_rd_byte   <= w_fwd_byte;
      r_rd_lane   <= w_rd_lane;
      r_rdata     <= w_rdata;
    end
  end

  assign o_rdata      = w_rdata;
  assign o_idle       = ~w_pending;
  assign o_mem_csb0   = ~w_flush;
  assign o_mem_web0   = 1'b0;
  assign o_mem_wmask0 = r_buf_mask;
  assign o_mem_addr0  = r_buf_addr;
  assign o_mem_din0   = r_buf_data;
  assign o_mem_csb1   = ~(i_ren & ~i_rst);
  assign o_mem_addr1  = w_rd_word;

endmodule

// File: tb/tb_subservient_sram_bridge.sv
// Bench: DW=32 and DW=64 bridges driven in parallel, each with its own macro
// model, checked against a flat byte-array reference memory.
module tb_subservient_sram_bridge;
  localparam int AW = 13;
  localparam int FC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wen = 1'b0, ren = 1'b0, flush = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [7:0]    wdata = '0;

  logic [7:0]  rdata32, rdata64;
  logic        idle32, idle64, csb0_32, csb0_64, web0_32, web0_64, csb1_32, csb1_64;
  logic [3:0]  wmask32;
  logic [7:0]  wmask64;
  logic [10:0] addr0_32, addr1_32;
  logic [9:0]  addr0_64, addr1_64;
  logic [31:0] din32, dout32;
  logic [63:0] din64, dout64;

  subservient_sram_bridge #(.AW(AW), .DW(32), .FLUSH_CYCLES(FC)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
    .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata32), .i_flush(flush), .o_idle(idle32),
    .o_mem_csb0(csb0_32), .o_mem_web0(web0_32), .o_mem_wmask0(wmask32),
    .o_mem_addr0(addr0_32), .o_mem_din0(din32), .o_mem_csb1(csb1_32),
    .o_mem_addr1(addr1_32), .i_mem_dout1(dout32)
  );

  subservient_sram_bridge #(.AW(AW), .DW(64), .FLUSH_CYCLES(FC)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
    .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata64), .i_flush(flush), .o_idle(idle64),
    .o_mem_csb0(csb0_64), .o_mem_web0(web0_64), .o_mem_wmask0(wmask64),
    .o_mem_addr0(addr0_64), .o_mem_din0(din64), .o_mem_csb1(csb1_64),
    .o_mem_addr1(addr1_64), .i_mem_dout1(dout64)
  );

  logic [7:0]  ref_mem [2**AW];
  logic [31:0] mem32 [2048];
  logic [63:0] mem64 [1024];
  logic        do_init = 1'b1;
  int          wr32 = 0, wr64 = 0;

  // Macro models; the first edge loads them from the reference image.
  always @(posedge clk) begin
    if (do_init) begin
      for (int w = 0; w < 2048; w++)
        for (int l = 0; l < 4; l++) mem32[w][8*l +: 8] <= ref_mem[4*w + l];
      for (int w = 0; w < 1024; w++)
        for (int l = 0; l < 8; l++) mem64[w][8*l +: 8] <= ref_mem[8*w + l];
    end else begin
      if (!csb0_32 && !web0_32) begin
        wr32 <= wr32 + 1;
        for (int l = 0; l < 4; l++) if (wmask32[l]) mem32[addr0_32][8*l +: 8] <= din32[8*l +: 8];
      end
      if (!csb0_64 && !web0_64) begin
        wr64 <= wr64 + 1;
        for (int l = 0; l < 8; l++) if (wmask64[l]) mem64[addr0_64][8*l +: 8] <= din64[8*l +: 8];
      end
    end
    if (!csb1_32) dout32 <= mem32[addr1_32];
    if (!csb1_64) dout64 <= mem64[addr1_64];
  end

  int         n_cmp = 0, n_bad = 0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_rd = 8'h00;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, update the model.
  task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [7:0] wd,
                     input logic r, input logic [AW-1:0] ra, input logic f,
                     input logic rs, input logic upd);
    @(posedge clk);
    #1;
    rst = rs; wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra; flush = f;
    @(negedge clk);
    if (exp_valid) begin
      check_val("rdata32", rdata32, exp_rd);
      check_val("rdata64", rdata64, exp_rd);
    end
    if (rs) begin
      exp_valid = 1'b1;
      exp_rd    = 8'h00;
    end else begin
      if (r) exp_rd = (w && wa == ra) ? wd : ref_mem[ra];
      if (w && upd) ref_mem[wa] = wd;
    end
  endtask

  task automatic idle_cyc();
    cyc(1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wr_cyc(input logic [AW-1:0] wa, input logic [7:0] wd);
    cyc(1'b1, wa, wd, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic flush_cyc();
    cyc(1'b0, '0, 8'h00, 1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  int         w32_0, w64_0;
  logic [7:0] b32, b64;

  initial begin
    for (int b = 0; b < 2**AW; b++) ref_mem[b] = 8'($urandom);
    cyc(1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    do_init = 1'b0;
    cyc(1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_val("rst_idle32", idle32, 1);
    check_val("rst_idle64", idle64, 1);
    check_val("rst_csb0_32", csb0_32, 1);
    check_val("rst_csb1_32", csb1_32, 1);
    check_val("rst_rdata32", rdata32, 0);

    // Four bytes fill one 32-bit word: a single full-mask write the next cycle.
    w32_0 = wr32; w64_0 = wr64;
    for (int i = 0; i < 4; i++) wr_cyc(AW'(32'h100 + i), 8'(8'h11 * (i + 1)));
    idle_cyc();
    check_val("coal_csb0_32", csb0_32, 0);
    check_val("coal_addr0_32", addr0_32, 11'h40);
    check_val("coal_mask_32", wmask32, 4'hF);
    check_val("coal_din_32", din32, 32'h44332211);
    check_val("coal_csb0_64", csb0_64, 1);
    flush_cyc();
    check_val("fl_csb0_64", csb0_64, 0);
    check_val("fl_mask_64", wmask64, 8'h0F);
    check_val("fl_addr0_64", addr0_64, 10'h20);
    check_val("fl_din_64", din64[31:0], 32'h44332211);
    check_val("fl_csb0_32", csb0_32, 1);
    idle_cyc();
    check_val("coal_idle32", idle32, 1);
    check_val("coal_idle64", idle64, 1);
    check_val("coal_nwr32", wr32 - w32_0, 1);
    check_val("coal_nwr64", wr64 - w64_0, 1);

    // A write to another word evicts the buffered one in the same cycle.
    wr_cyc(AW'(13'h10), 8'hAA);
    wr_cyc(AW'(13'h20), 8'hBB);
    check_val("evict_csb0_32", csb0_32, 0);
    check_val("evict_addr0_32", addr0_32, 11'h4);
    check_val("evict_mask_32", wmask32, 4'h1);
    check_val("evict_din_32", din32[7:0], 8'hAA);
    check_val("evict_idle32", idle32, 0);
    check_val("evict_csb0_64", csb0_64, 0);
    check_val("evict_addr0_64", addr0_64, 10'h2);
    check_val("evict_mask_64", wmask64, 8'h01);
    idle_cyc();
    check_val("evict_idle32_b", idle32, 0);
    flush_cyc();
    idle_cyc();

    // Timeout flush after FC quiet cycles.
    wr_cyc(AW'(13'h33), 8'h5A);
    for (int k = 0; k < FC; k++) begin
      idle_cyc();
      check_val("tmo_early_csb0_32", csb0_32, 1);
    end
    idle_cyc();
    check_val("tmo_csb0_32", csb0_32, 0);
    check_val("tmo_mask_32", wmask32, 4'h8);
    check_val("tmo_din_32", din32[31:24], 8'h5A);
    check_val("tmo_csb0_64", csb0_64, 0);
    check_val("tmo_mask_64", wmask64, 8'h08);
    idle_cyc();
    check_val("tmo_idle32", idle32, 1);
    check_val("tmo_idle64", idle64, 1);

    // Same-cycle write/read forwarding, then a macro-lane read.
    cyc(1'b1, AW'(13'h40), 8'h77, 1'b1, AW'(13'h40), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 8'h00, 1'b1, AW'(13'h41), 1'b0, 1'b0, 1'b1);
    idle_cyc();
    b32 = dout32[15:8];
    b64 = dout64[15:8];
    check_val("lane_rd32", rdata32, {24'h0, b32});
    check_val("lane_rd64", rdata64, {56'h0, b64});
    flush_cyc();
    idle_cyc();

    // Eight bytes fill one 64-bit word.
    w64_0 = wr64;
    for (int i = 0; i < 8; i++) wr_cyc(AW'(i), 8'(8'hA0 + i));
    idle_cyc();
    check_val("w64_csb0", csb0_64, 0);
    check_val("w64_mask", wmask64, 8'hFF);
    check_val("w64_addr0", addr0_64, 10'h0);
    check_val("w64_din", din64, 64'hA7A6A5A4A3A2A1A0);
    cyc(1'b0, '0, 8'h00, 1'b1, AW'(5), 1'b0, 1'b0, 1'b1);
    idle_cyc();
    b64 = dout64[47:40];
    check_val("w64_lane_rd", rdata64, {56'h0, b64});
    check_val("w64_nwr", wr64 - w64_0, 1);

    // Reset with a pending byte: it is discarded, never written.
    w32_0 = wr32; w64_0 = wr64;
    cyc(1'b1, AW'(13'h200), 8'h99, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle_cyc();
    check_val("rstp_csb0_32", csb0_32, 1);
    check_val("rstp_idle32", idle32, 1);
    check_val("rstp_idle64", idle64, 1);
    check_val("rstp_nwr32", wr32 - w32_0, 0);
    check_val("rstp_nwr64", wr64 - w64_0, 0);

    // Random traffic over a small window to force merges, evictions and forwarding.
    for (int n = 0; n < 800; n++) begin
      cyc(1'($urandom), AW'($urandom_range(0, 47)), 8'($urandom),
          1'($urandom), AW'($urandom_range(0, 47)), ($urandom_range(0, 15) == 0),
          1'b0, 1'b1);
    end
    flush_cyc();
    idle_cyc();
    check_val("end_idle32", idle32, 1);
    check_val("end_idle64", idle64, 1);
    for (int b = 0; b < 13'h240; b++) begin
      b32 = mem32[b / 4][8*(b % 4) +: 8];
      b64 = mem64[b / 8][8*(b % 8) +: 8];
      check_val("mem32", b32, ref_mem[b]);
      check_val("mem64", b64, ref_mem[b]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
